// File: rtl/sdram_frame_arbiter.sv
// Arbitrates SDRAM write/read bursts for a multi-buffer frame store and tracks which buffer each side owns.
// Latency: a request asserts two clocks after its grant condition; addresses and pulses are registered (1 clock).
// Backpressure: bursts are granted only when FIFO levels allow; a pending read wins after STARVE_MAX write grants.

module sdram_frame_arbiter #(
  parameter int            AW         = 21,
  parameter int            LW         = 10,
  parameter int            BUF_NUM    = 3,
  parameter logic [AW-1:0] BUF_SIZE   = 21'd307200,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int            STARVE_MAX = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          init_end,
  input  logic          read_valid,
  input  logic [LW-1:0] wr_fifo_num,
  input  logic [LW-1:0] rd_fifo_num,
  input  logic [LW-1:0] wr_burst_len,
  input  logic [LW-1:0] rd_burst_len,
  input  logic [AW-1:0] frame_words,
  input  logic          sdram_wr_ack,
  input  logic          sdram_rd_ack,
  output logic          sdram_wr_req,
  output logic          sdram_rd_req,
  output logic [AW-1:0] sdram_wr_addr,
  output logic [AW-1:0] sdram_rd_addr,
  output logic [1:0]    wr_buf_idx,
  output logic [1:0]    rd_buf_idx,
  output logic          frame_valid,
  output logic          wr_frame_end,
  output logic          rd_frame_end,
  output logic          wr_frame_drop
);

  localparam int SW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic          wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic          wr_mask_q, wr_mask_d, rd_mask_q, rd_mask_d;
  logic [AW-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [1:0]    wr_buf_idx_q, wr_buf_idx_d, rd_buf_idx_q, rd_buf_idx_d;
  logic [1:0]    last_done_q, last_done_d, wr_nxt;
  logic          new_frame_q, new_frame_d, frame_valid_q, frame_valid_d;
  logic          wr_frame_end_q, wr_frame_end_d, rd_frame_end_q, rd_frame_end_d;
  logic          wr_frame_drop_q, wr_frame_drop_d;
  logic          wr_fall, rd_fall, wr_last, rd_last, wr_end_ev, rd_end_ev;
  logic          wr_cond, rd_cond;
  logic [AW-1:0] wr_len_ext, rd_len_ext;

  assign wr_len_ext = AW'(wr_burst_len);
  assign rd_len_ext = AW'(rd_burst_len);
  assign wr_fall    = wr_ack_q & ~sdram_wr_ack;
  assign rd_fall    = rd_ack_q & ~sdram_rd_ack;
  assign wr_last    = !(wr_off_q < (frame_words - wr_len_ext));
  assign rd_last    = !(rd_off_q < (frame_words - rd_len_ext));
  assign wr_end_ev  = wr_fall & wr_last;
  assign rd_end_ev  = rd_fall & rd_last;
  assign wr_cond    = (wr_fifo_num >= wr_burst_len);
  assign rd_cond    = read_valid & frame_valid_q & (rd_fifo_num < rd_burst_len);

  // Ack delay line; the mask hides the tail of a burst that was aborted by reset until its ack goes low.
  always_comb begin
    wr_ack_d  = sdram_wr_ack & ~wr_mask_q;
    rd_ack_d  = sdram_rd_ack & ~rd_mask_q;
    wr_mask_d = wr_mask_q & sdram_wr_ack;
    rd_mask_d = rd_mask_q & sdram_rd_ack;
  end

  // Arbiter next state, starvation counter and registered request levels.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wr_req_d = 1'b0;
    rd_req_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_end) begin
          if (rd_cond && (starve_q == SW'(STARVE_MAX))) begin
            state_d  = ST_RD;
            starve_d = '0;
          end else if (wr_cond) begin
            state_d = ST_WR;
            if (rd_cond) starve_d = starve_q + SW'(1);
          end else if (rd_cond) begin
            state_d  = ST_RD;
            starve_d = '0;
          end
        end
      end
      ST_WR: begin
        wr_req_d = ~sdram_wr_ack & ~wr_ack_q;
        if (wr_fall) state_d = ST_IDLE;
      end
      ST_RD: begin
        rd_req_d = ~sdram_rd_ack & ~rd_ack_q;
        if (rd_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst offsets and buffer ownership; the reader is resolved first so the writer checks the new reader index.
  always_comb begin
    wr_off_d        = wr_off_q;
    rd_off_d        = rd_off_q;
    wr_buf_idx_d    = wr_buf_idx_q;
    rd_buf_idx_d    = rd_buf_idx_q;
    last_done_d     = last_done_q;
    new_frame_d     = new_frame_q;
    frame_valid_d   = frame_valid_q;
    wr_frame_end_d  = wr_end_ev;
    rd_frame_end_d  = rd_end_ev;
    wr_frame_drop_d = 1'b0;
    wr_nxt          = (wr_buf_idx_q == 2'(BUF_NUM - 1)) ? 2'd0 : wr_buf_idx_q + 2'd1;
    if (wr_fall) wr_off_d = wr_last ? '0 : wr_off_q + wr_len_ext;
    if (rd_fall) rd_off_d = rd_last ? '0 : rd_off_q + rd_len_ext;
    if (wr_end_ev) last_done_d = wr_buf_idx_q;
    if (wr_end_ev && !frame_valid_q) begin
      rd_buf_idx_d  = wr_buf_idx_q;
      frame_valid_d = 1'b1;
    end else if (wr_end_ev && rd_end_ev) begin
      rd_buf_idx_d = wr_buf_idx_q;
      new_frame_d  = 1'b0;
    end else if (wr_end_ev) begin
      new_frame_d = 1'b1;
    end else if (rd_end_ev && new_frame_q) begin
      rd_buf_idx_d = last_done_q;
      new_frame_d  = 1'b0;
    end
    if (wr_end_ev) begin
      if (wr_nxt == rd_buf_idx_d) wr_frame_drop_d = 1'b1;
      else                        wr_buf_idx_d    = wr_nxt;
    end
  end

  // Burst start addresses follow the updated buffer index and offset.
  always_comb begin
    wr_addr_d = BASE_ADDR + (AW'(wr_buf_idx_d) * BUF_SIZE) + wr_off_d;
    rd_addr_d = BASE_ADDR + (AW'(rd_buf_idx_d) * BUF_SIZE) + rd_off_d;
  end

  // State register with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= ST_IDLE;
      starve_q        <= '0;
      wr_req_q        <= 1'b0;
      rd_req_q        <= 1'b0;
      wr_ack_q        <= 1'b0;
      rd_ack_q        <= 1'b0;
      wr_mask_q       <= 1'b1;
      rd_mask_q       <= 1'b1;
      wr_off_q        <= '0;
      rd_off_q        <= '0;
      wr_addr_q       <= BASE_ADDR;
      rd_addr_q       <= BASE_ADDR + (AW'(BUF_NUM - 1) * BUF_SIZE);
      wr_buf_idx_q    <= 2'd0;
      rd_buf_idx_q    <= 2'(BUF_NUM - 1);
      last_done_q     <= 2'd0;
      new_frame_q     <= 1'b0;
      frame_valid_q   <= 1'b0;
      wr_frame_end_q  <= 1'b0;
      rd_frame_end_q  <= 1'b0;
      wr_frame_drop_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      wr_req_q        <= wr_req_d;
      rd_req_q        <= rd_req_d;
      wr_ack_q        <= wr_ack_d;
      rd_ack_q        <= rd_ack_d;
      wr_mask_q       <= wr_mask_d;
      rd_mask_q       <= rd_mask_d;
      wr_off_q        <= wr_off_d;
      rd_off_q        <= rd_off_d;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      wr_buf_idx_q    <= wr_buf_idx_d;
      rd_buf_idx_q    <= rd_buf_idx_d;
      last_done_q     <= last_done_d;
      new_frame_q     <= new_frame_d;
      frame_valid_q   <= frame_valid_d;
      wr_frame_end_q  <= wr_frame_end_d;
      rd_frame_end_q  <= rd_frame_end_d;
      wr_frame_drop_q <= wr_frame_drop_d;
    end
  end

  // Requests are held off combinationally while the SDRAM is still initialising.
  assign sdram_wr_req  = wr_req_q & init_end;
  assign sdram_rd_req  = rd_req_q & init_end;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;
  assign wr_buf_idx    = wr_buf_idx_q;
  assign rd_buf_idx    = rd_buf_idx_q;
  assign frame_valid   = frame_valid_q;
  assign wr_frame_end  = wr_frame_end_q;
  assign rd_frame_end  = rd_frame_end_q;
  assign wr_frame_drop = wr_frame_drop_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter: a 3-buffer and a 2-buffer instance share all stimulus.
// Latency: checks sample at the falling edge, inputs change at the falling edge.
// Backpressure: the bench acts as the SDRAM controller, answering each request with an ack burst.

module tb_sdram_frame_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic        read_valid = 1'b0;
  logic [9:0]  wr_fifo_num = '0;
  logic [9:0]  rd_fifo_num = '0;
  logic [9:0]  wr_burst_len = '0;
  logic [9:0]  rd_burst_len = '0;
  logic [20:0] frame_words = '0;
  logic        sdram_wr_ack = 1'b0;
  logic        sdram_rd_ack = 1'b0;

  logic        o3_wr_req, o3_rd_req, o3_fv, o3_wfe, o3_rfe, o3_drop;
  logic [20:0] o3_wr_addr, o3_rd_addr;
  logic [1:0]  o3_wr_idx, o3_rd_idx;
  logic        o2_wr_req, o2_rd_req, o2_fv, o2_wfe, o2_rfe, o2_drop;
  logic [20:0] o2_wr_addr, o2_rd_addr;
  logic [1:0]  o2_wr_idx, o2_rd_idx;

  int checks = 0;
  int errors = 0;
  int wfe3_cnt = 0;
  int rfe3_cnt = 0;
  int ovl_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_frame_arbiter u3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .read_valid(read_valid),
    .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num), .wr_burst_len(wr_burst_len),
    .rd_burst_len(rd_burst_len), .frame_words(frame_words), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_ack(sdram_rd_ack), .sdram_wr_req(o3_wr_req), .sdram_rd_req(o3_rd_req),
    .sdram_wr_addr(o3_wr_addr), .sdram_rd_addr(o3_rd_addr), .wr_buf_idx(o3_wr_idx),
    .rd_buf_idx(o3_rd_idx), .frame_valid(o3_fv), .wr_frame_end(o3_wfe),
    .rd_frame_end(o3_rfe), .wr_frame_drop(o3_drop)
  );

  sdram_frame_arbiter #(.BUF_NUM(2)) u2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .read_valid(read_valid),
    .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num), .wr_burst_len(wr_burst_len),
    .rd_burst_len(rd_burst_len), .frame_words(frame_words), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_ack(sdram_rd_ack), .sdram_wr_req(o2_wr_req), .sdram_rd_req(o2_rd_req),
    .sdram_wr_addr(o2_wr_addr), .sdram_rd_addr(o2_rd_addr), .wr_buf_idx(o2_wr_idx),
    .rd_buf_idx(o2_rd_idx), .frame_valid(o2_fv), .wr_frame_end(o2_wfe),
    .rd_frame_end(o2_rfe), .wr_frame_drop(o2_drop)
  );

  // Pulse and overlap monitors (values are stable just before each rising edge).
  always @(posedge sys_clk) begin
    if (o3_wfe) wfe3_cnt++;
    if (o3_rfe) rfe3_cnt++;
    if ((o3_wr_req && o3_rd_req) || (o2_wr_req && o2_rd_req)) ovl_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_req"},   {31'd0, o3_wr_req},  0);
    chk({tag, "_rd_req"},   {31'd0, o3_rd_req},  0);
    chk({tag, "_wr_addr"},  {11'd0, o3_wr_addr}, 0);
    chk({tag, "_rd_addr"},  {11'd0, o3_rd_addr}, 614400);
    chk({tag, "_wr_idx"},   {30'd0, o3_wr_idx},  0);
    chk({tag, "_rd_idx"},   {30'd0, o3_rd_idx},  2);
    chk({tag, "_pulses"},   {29'd0, o3_fv, o3_wfe, o3_rfe} | {31'd0, o3_drop}, 0);
    chk({tag, "_u2_rd_addr"}, {11'd0, o2_rd_addr}, 307200);
    chk({tag, "_u2_rd_idx"},  {30'd0, o2_rd_idx},  1);
    chk({tag, "_u2_misc"}, {11'd0, o2_wr_addr} | {30'd0, o2_wr_idx} |
        {26'd0, o2_wr_req, o2_rd_req, o2_fv, o2_wfe, o2_rfe, o2_drop}, 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Hold the chosen acks for n cycles, drop them, and return one cycle after the fall edge.
  task automatic burst(input logic w, input logic r, input int n);
    sdram_wr_ack = w;
    sdram_rd_ack = r;
    repeat (n) @(negedge sys_clk);
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_req(input string name, output logic got_wr, output logic got_rd);
    got_wr = 1'b0;
    got_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (o3_wr_req || o3_rd_req) begin
        got_wr = o3_wr_req;
        got_rd = o3_rd_req;
        break;
      end
    end
    checks++;
    if (!(got_wr || got_rd)) begin
      errors++;
      $display("FAIL %s actual=no_request expected=request_within_20_cycles", name);
    end
  endtask

  typedef struct {
    logic       init;
    logic       rv;
    logic [9:0] wfn;
    logic [9:0] wbl;
    logic [9:0] rfn;
    logic [9:0] rbl;
    logic       exp_wr;
    logic       exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic gw, gr;
    int   wfe_snap, rfe_snap;

    vecs[0] = '{1'b0, 1'b0, 10'd512, 10'd512, 10'd0, 10'd512, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 10'd511, 10'd512, 10'd0, 10'd512, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 10'd512, 10'd512, 10'd0, 10'd512, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 10'd600, 10'd512, 10'd0, 10'd512, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 10'd0,   10'd512, 10'd0, 10'd512, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 10'd4,   10'd4,   10'd0, 10'd512, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 10'd0,   10'd0,   10'd0, 10'd512, 1'b1, 1'b0};

    frame_words = 21'd1024;
    @(negedge sys_clk);
    check_reset("reset");

    // Grant decisions straight out of reset (no frame stored, so reads never win).
    for (int i = 0; i < 7; i++) begin
      sys_rst      = 1'b1;
      init_end     = vecs[i].init;
      read_valid   = vecs[i].rv;
      wr_fifo_num  = vecs[i].wfn;
      wr_burst_len = vecs[i].wbl;
      rd_fifo_num  = vecs[i].rfn;
      rd_burst_len = vecs[i].rbl;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk($sformatf("vec%0d_wr_req", i), {31'd0, o3_wr_req}, {31'd0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_rd_req", i), {31'd0, o3_rd_req}, {31'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_wr_addr", i), {11'd0, o3_wr_addr}, 0);
    end

    // Basic write grant and first frame.
    init_end = 1'b1; read_valid = 1'b0;
    wr_fifo_num = 10'd512; wr_burst_len = 10'd512;
    rd_fifo_num = 10'd0;   rd_burst_len = 10'd512;
    do_reset();
    wfe_snap = wfe3_cnt;
    @(negedge sys_clk);
    chk("grant_latency_1edge", {31'd0, o3_wr_req}, 0);
    @(negedge sys_clk);
    chk("grant_latency_2edge", {31'd0, o3_wr_req}, 1);
    chk("first_wr_addr", {11'd0, o3_wr_addr}, 0);
    burst(1'b1, 1'b0, 512);
    chk("wr_addr_after_burst", {11'd0, o3_wr_addr}, 512);
    chk("no_frame_end_mid", {31'd0, o3_wfe}, 0);
    wait_req("second_grant", gw, gr);
    chk("second_grant_is_wr", {30'd0, gw, gr}, 2);
    burst(1'b1, 1'b0, 512);
    chk("frame_end_pulse", {31'd0, o3_wfe}, 1);
    chk("frame_valid", {31'd0, o3_fv}, 1);
    chk("rd_idx_first_frame", {30'd0, o3_rd_idx}, 0);
    chk("wr_idx_first_frame", {30'd0, o3_wr_idx}, 1);
    chk("wr_addr_buf1", {11'd0, o3_wr_addr}, 307200);
    chk("u2_wr_idx_first_frame", {30'd0, o2_wr_idx}, 1);

    // Second frame: 3-buffer writer advances, 2-buffer writer would hit the reader and drops.
    wait_req("frame2_grant_a", gw, gr);
    chk("frame_end_once", wfe3_cnt - wfe_snap, 1);
    burst(1'b1, 1'b0, 8);
    wait_req("frame2_grant_b", gw, gr);
    burst(1'b1, 1'b0, 8);
    wr_fifo_num = 10'd0;
    chk("u2_drop_pulse", {31'd0, o2_drop}, 1);
    chk("u2_wr_idx_kept", {30'd0, o2_wr_idx}, 1);
    chk("u2_wr_addr_kept", {11'd0, o2_wr_addr}, 307200);
    chk("u3_no_drop", {31'd0, o3_drop}, 0);
    chk("u3_wr_idx_frame2", {30'd0, o3_wr_idx}, 2);
    @(negedge sys_clk);
    chk("u2_drop_one_cycle", {31'd0, o2_drop}, 0);

    // Coincident frame ends driven without grants (offsets still advance while idle).
    burst(1'b0, 1'b1, 8);
    chk("rd_addr_half", {11'd0, o3_rd_addr}, 512);
    burst(1'b1, 1'b0, 8);
    burst(1'b1, 1'b1, 8);
    chk("coinc_pulses", {30'd0, o3_wfe, o3_rfe}, 3);
    chk("coinc_rd_idx", {30'd0, o3_rd_idx}, 2);
    chk("coinc_wr_idx", {30'd0, o3_wr_idx}, 0);
    chk("coinc_rd_addr", {11'd0, o3_rd_addr}, 614400);
    chk("u2_coinc_idx", {28'd0, o2_rd_idx, o2_wr_idx}, 4);

    // Starvation guard: four write grants, then the pending read wins.
    read_valid = 1'b1; rd_fifo_num = 10'd0; wr_fifo_num = 10'd512;
    for (int k = 0; k < 5; k++) begin
      wait_req($sformatf("starve_grant%0d", k), gw, gr);
      chk($sformatf("starve_grant%0d_kind", k), {30'd0, gw, gr}, (k == 4) ? 1 : 2);
      burst(gw, gr, 4);
    end
    read_valid = 1'b0; wr_fifo_num = 10'd0;
    @(negedge sys_clk);
    chk("req_overlap", ovl_cnt, 0);

    // Reset in the middle of a read burst; the ack tail after release must be ignored.
    sdram_rd_ack = 1'b1;
    repeat (3) @(negedge sys_clk);
    do_reset();
    check_reset("midburst");
    rfe_snap = rfe3_cnt;
    repeat (2) @(negedge sys_clk);
    sdram_rd_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("post_reset_rd_addr", {11'd0, o3_rd_addr}, 614400);
    chk("post_reset_u2_rd_addr", {11'd0, o2_rd_addr}, 307200);
    chk("post_reset_no_rd_end", rfe3_cnt - rfe_snap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
